// File: rtl/sw_pkg.sv
// Shared types and constants for the AXI-Stream crossbar switch.
// Holds the input FSM state encoding, the destination-width helper and counter width.
package sw_pkg;

  localparam int DROP_CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    XFER,
    DROP
  } in_state_t;

  function automatic int dest_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/axis_xbar_switch_if.sv
// Bundled per-input and per-output AXI-Stream signals of the crossbar switch.
// The slave modport is the switch view; master is the surrounding source/sink view.
interface axis_xbar_switch_if #(
  parameter int PORT_NUM = 4,
  parameter int DATA_W   = 32
);
  import sw_pkg::*;

  localparam int KEEP_W = DATA_W / 8;
  localparam int DEST_W = dest_w(PORT_NUM);

  logic [PORT_NUM-1:0]        s_axis_tvalid;
  logic [PORT_NUM-1:0]        s_axis_tready;
  logic [PORT_NUM-1:0]        s_axis_tlast;
  logic [PORT_NUM-1:0]        s_axis_tlb;
  logic [PORT_NUM*DATA_W-1:0] s_axis_tdata;
  logic [PORT_NUM*KEEP_W-1:0] s_axis_tkeep;
  logic [PORT_NUM*DEST_W-1:0] s_axis_tdest;

  logic [PORT_NUM-1:0]        m_axis_tvalid;
  logic [PORT_NUM-1:0]        m_axis_tready;
  logic [PORT_NUM-1:0]        m_axis_tlast;
  logic [PORT_NUM*DATA_W-1:0] m_axis_tdata;
  logic [PORT_NUM*KEEP_W-1:0] m_axis_tkeep;

  modport slave (
    input  s_axis_tvalid, s_axis_tlast, s_axis_tlb, s_axis_tdata, s_axis_tkeep, s_axis_tdest,
    output s_axis_tready,
    output m_axis_tvalid, m_axis_tlast, m_axis_tdata, m_axis_tkeep,
    input  m_axis_tready
  );

  modport master (
    output s_axis_tvalid, s_axis_tlast, s_axis_tlb, s_axis_tdata, s_axis_tkeep, s_axis_tdest,
    input  s_axis_tready,
    input  m_axis_tvalid, m_axis_tlast, m_axis_tdata, m_axis_tkeep,
    output m_axis_tready
  );

endinterface

// File: rtl/axis_xbar_switch_rr_arbiter.sv
// Round-robin arbiter for one crossbar output: registered grant held until release.
// win is the one-hot decision being loaded into grant this cycle.
module rr_arbiter
  import sw_pkg::*;
#(
  parameter int PORT_NUM = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [PORT_NUM-1:0] req,
  input  logic                rel,
  output logic [PORT_NUM-1:0] grant,
  output logic [PORT_NUM-1:0] win
);
  localparam int PW = dest_w(PORT_NUM);

  logic [PW-1:0] ptr;
  logic [PW-1:0] ptr_nxt;
  logic [PW-1:0] sel;
  logic          found;

  // search starts at the pointer; the first requester found wins
  always_comb begin
    win     = '0;
    ptr_nxt = ptr;
    sel     = '0;
    found   = 1'b0;
    if (!(|grant) && !rel) begin
      for (int k = 0; k < PORT_NUM; k++) begin
        sel = PW'((int'(ptr) + k) % PORT_NUM);
        if (!found && req[sel]) begin
          found      = 1'b1;
          win[sel]   = 1'b1;
          ptr_nxt    = PW'((int'(sel) + 1) % PORT_NUM);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      grant <= '0;
      ptr   <= '0;
    end else if (rel) begin
      grant <= '0;
    end else if (found) begin
      grant <= win;
      ptr   <= ptr_nxt;
    end
  end

endmodule

// File: rtl/axis_xbar_switch.sv
// AXI-Stream crossbar: per-input destination FSMs, per-output round-robin locks,
// zero-latency combinational data path once a grant is held, and drop counting.
module axis_xbar_switch
  import sw_pkg::*;
#(
  parameter int PORT_NUM = 4,
  parameter int DATA_W   = 32,
  parameter int LB_EN    = 1
) (
  input  logic                    glb_clk,
  input  logic                    glb_rst,
  axis_xbar_switch_if.slave       bus,
  input  logic [PORT_NUM*32-1:0]  fifo_space_used,
  output logic [DROP_CNT_W-1:0]   drop_cnt
);
  localparam int KEEP_W = DATA_W / 8;
  localparam int DEST_W = dest_w(PORT_NUM);

  in_state_t                  state    [PORT_NUM];
  logic [DEST_W-1:0]          dest     [PORT_NUM];
  logic [DEST_W-1:0]          dest_sel [PORT_NUM];
  logic [PORT_NUM-1:0]        req      [PORT_NUM];
  logic [PORT_NUM-1:0]        gnt      [PORT_NUM];
  logic [PORT_NUM-1:0]        win      [PORT_NUM];
  logic [PORT_NUM-1:0]        rel;
  logic [PORT_NUM-1:0]        won;
  logic [PORT_NUM-1:0]        hs_last;
  logic [PORT_NUM-1:0]        s_rdy;
  logic [PORT_NUM-1:0]        m_vld;
  logic [PORT_NUM-1:0]        m_lst;
  logic [PORT_NUM*DATA_W-1:0] m_dat;
  logic [PORT_NUM*KEEP_W-1:0] m_kp;
  logic [DEST_W-1:0]          lb_dest;
  logic [31:0]                lb_min;
  logic [3:0]                 drop_inc;
  logic [DROP_CNT_W:0]        drop_sum;

  // least-occupied output; strict compare keeps ties on the lowest index
  always_comb begin
    lb_dest = '0;
    lb_min  = fifo_space_used[31:0];
    for (int j = 1; j < PORT_NUM; j++) begin
      if (fifo_space_used[j*32 +: 32] < lb_min) begin
        lb_min  = fifo_space_used[j*32 +: 32];
        lb_dest = DEST_W'(j);
      end
    end
  end

  always_comb begin
    for (int i = 0; i < PORT_NUM; i++) begin
      dest_sel[i] = (LB_EN != 0 && bus.s_axis_tlb[i]) ? lb_dest
                                                      : bus.s_axis_tdest[i*DEST_W +: DEST_W];
    end
  end

  assign hs_last = bus.s_axis_tvalid & s_rdy & bus.s_axis_tlast;

  always_comb begin
    won = '0;
    for (int d = 0; d < PORT_NUM; d++) begin
      req[d] = '0;
      rel[d] = |(gnt[d] & hs_last);
      won    = won | win[d];
      for (int i = 0; i < PORT_NUM; i++) begin
        req[d][i] = (state[i] == REQ) && (dest[i] == DEST_W'(d));
      end
    end
  end

  for (genvar d = 0; d < PORT_NUM; d++) begin : g_arb
    rr_arbiter #(.PORT_NUM(PORT_NUM)) u_arb (
      .clk   (glb_clk),
      .rst   (glb_rst),
      .req   (req[d]),
      .rel   (rel[d]),
      .grant (gnt[d]),
      .win   (win[d])
    );
  end

  // the held grant alone steers the data path, so forwarding adds no latency
  always_comb begin
    m_vld = '0;
    m_lst = '0;
    m_dat = '0;
    m_kp  = '0;
    for (int i = 0; i < PORT_NUM; i++) s_rdy[i] = (state[i] == DROP);
    for (int d = 0; d < PORT_NUM; d++) begin
      for (int i = 0; i < PORT_NUM; i++) begin
        if (gnt[d][i]) begin
          m_vld[d]                  = bus.s_axis_tvalid[i];
          m_lst[d]                  = bus.s_axis_tlast[i];
          m_dat[d*DATA_W +: DATA_W] = bus.s_axis_tdata[i*DATA_W +: DATA_W];
          m_kp[d*KEEP_W +: KEEP_W]  = bus.s_axis_tkeep[i*KEEP_W +: KEEP_W];
          s_rdy[i]                  = bus.m_axis_tready[d];
        end
      end
    end
  end

  assign bus.s_axis_tready = s_rdy;
  assign bus.m_axis_tvalid = m_vld;
  assign bus.m_axis_tlast  = m_lst;
  assign bus.m_axis_tdata  = m_dat;
  assign bus.m_axis_tkeep  = m_kp;

  always_comb begin
    drop_inc = '0;
    for (int i = 0; i < PORT_NUM; i++) begin
      if (state[i] == DROP && hs_last[i]) drop_inc = drop_inc + 4'd1;
    end
  end

  assign drop_sum = {1'b0, drop_cnt} + {{(DROP_CNT_W-3){1'b0}}, drop_inc};

  always_ff @(posedge glb_clk) begin
    for (int i = 0; i < PORT_NUM; i++) begin
      if (state[i] == IDLE && bus.s_axis_tvalid[i]) dest[i] <= dest_sel[i];
    end
  end

  always_ff @(posedge glb_clk) begin
    if (glb_rst) begin
      for (int i = 0; i < PORT_NUM; i++) state[i] <= IDLE;
      drop_cnt <= '0;
    end else begin
      drop_cnt <= drop_sum[DROP_CNT_W] ? '1 : drop_sum[DROP_CNT_W-1:0];
      for (int i = 0; i < PORT_NUM; i++) begin
        case (state[i])
          IDLE: if (bus.s_axis_tvalid[i])
                  state[i] <= (int'(dest_sel[i]) >= PORT_NUM) ? DROP : REQ;
          REQ:  if (won[i]) state[i] <= XFER;
          XFER: if (hs_last[i]) state[i] <= IDLE;
          DROP: if (hs_last[i]) state[i] <= IDLE;
          default: state[i] <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_axis_xbar_switch.sv
// Directed bench for axis_xbar_switch: a 4-port instance with a scoreboard monitor
// on every output, and a 3-port instance exercising the drop path.
module tb_axis_xbar_switch;
  import sw_pkg::*;

  localparam int N  = 4;
  localparam int N3 = 3;
  localparam int DW = 32;

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  k;
    logic        l;
  } beat_t;

  logic clk = 1'b0;
  logic rst;
  initial forever #5 clk = ~clk;

  axis_xbar_switch_if #(.PORT_NUM(N),  .DATA_W(DW)) bus4 ();
  axis_xbar_switch_if #(.PORT_NUM(N3), .DATA_W(DW)) bus3 ();

  logic [N*32-1:0]  fifo4;
  logic [N3*32-1:0] fifo3;
  logic [15:0]      dcnt4;
  logic [15:0]      dcnt3;

  axis_xbar_switch #(.PORT_NUM(N), .DATA_W(DW), .LB_EN(1)) dut4 (
    .glb_clk(clk), .glb_rst(rst), .bus(bus4), .fifo_space_used(fifo4), .drop_cnt(dcnt4));
  axis_xbar_switch #(.PORT_NUM(N3), .DATA_W(DW), .LB_EN(1)) dut3 (
    .glb_clk(clk), .glb_rst(rst), .bus(bus3), .fifo_space_used(fifo3), .drop_cnt(dcnt3));

  logic          s_vld [N];
  logic          s_lst [N];
  logic          s_lb  [N];
  logic [DW-1:0] s_dat [N];
  logic [3:0]    s_kp  [N];
  logic [1:0]    s_dst [N];
  logic [N-1:0]  m_rdy;

  for (genvar i = 0; i < N; i++) begin : g_drv
    assign bus4.s_axis_tvalid[i]       = s_vld[i];
    assign bus4.s_axis_tlast[i]        = s_lst[i];
    assign bus4.s_axis_tlb[i]          = s_lb[i];
    assign bus4.s_axis_tdata[i*32+:32] = s_dat[i];
    assign bus4.s_axis_tkeep[i*4+:4]   = s_kp[i];
    assign bus4.s_axis_tdest[i*2+:2]   = s_dst[i];
  end
  assign bus4.m_axis_tready = m_rdy;

  logic [N3-1:0]    d3_vld;
  logic [N3-1:0]    d3_lst;
  logic [N3*2-1:0]  d3_dst;
  assign bus3.s_axis_tvalid = d3_vld;
  assign bus3.s_axis_tlast  = d3_lst;
  assign bus3.s_axis_tlb    = '0;
  assign bus3.s_axis_tdata  = {3{32'hD0D0_0000}};
  assign bus3.s_axis_tkeep  = '1;
  assign bus3.s_axis_tdest  = d3_dst;
  assign bus3.m_axis_tready = '1;

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;
  beat_t exp_q   [N][$];
  int    stamp_q [N][$];

  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
  endtask

  function automatic int stamp(input int o, input int k);
    return (k < stamp_q[o].size()) ? stamp_q[o][k] : -1000;
  endfunction

  task automatic exp_pkt(input int o, input int nb, input logic [31:0] base);
    beat_t b;
    for (int k = 0; k < nb; k++) begin
      b.d = base + 32'(k);
      b.k = (k == nb - 1) ? 4'h3 : 4'hF;
      b.l = (k == nb - 1);
      exp_q[o].push_back(b);
    end
  endtask

  task automatic send_pkt(input int p, input int dst, input logic lb, input int nb,
                          input logic [31:0] base);
    logic hs;
    int   t;
    for (int k = 0; k < nb; k++) begin
      s_vld[p] = 1'b1;
      s_dat[p] = base + 32'(k);
      s_kp[p]  = (k == nb - 1) ? 4'h3 : 4'hF;
      s_lst[p] = (k == nb - 1);
      s_dst[p] = 2'(dst);
      s_lb[p]  = lb;
      hs = 1'b0;
      t  = 0;
      while (!hs && t < 200) begin
        @(negedge clk);
        hs = bus4.s_axis_tready[p];
        @(posedge clk);
        #1;
        t++;
      end
      if (!hs) begin
        chk($sformatf("handshake_in%0d", p), 64'(hs), 64'd1);
        break;
      end
    end
    s_vld[p] = 1'b0;
    s_lst[p] = 1'b0;
  endtask

  // scoreboard: every output beat must match the oldest expected beat for that output
  always @(negedge clk) begin
    beat_t e;
    for (int d = 0; d < N; d++) begin
      if (bus4.m_axis_tvalid[d] === 1'b1) begin
        chk($sformatf("beat_expected_out%0d", d), 64'(exp_q[d].size() > 0), 64'd1);
        if (m_rdy[d] && exp_q[d].size() > 0) begin
          e = exp_q[d].pop_front();
          chk($sformatf("tdata_out%0d", d), 64'(bus4.m_axis_tdata[d*32+:32]), 64'(e.d));
          chk($sformatf("tkeep_out%0d", d), 64'(bus4.m_axis_tkeep[d*4+:4]), 64'(e.k));
          chk($sformatf("tlast_out%0d", d), 64'(bus4.m_axis_tlast[d]), 64'(e.l));
          stamp_q[d].push_back(cyc);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    int tries;
    rst    = 1'b1;
    m_rdy  = '1;
    fifo4  = '0;
    fifo3  = '0;
    d3_vld = '0;
    d3_lst = '0;
    d3_dst = '0;
    for (int i = 0; i < N; i++) begin
      s_vld[i] = 1'b0; s_lst[i] = 1'b0; s_lb[i] = 1'b0;
      s_dat[i] = '0;   s_kp[i]  = '0;   s_dst[i] = '0;
    end

    repeat (3) @(posedge clk);
    #1;
    s_vld[0] = 1'b1;
    @(negedge clk);
    chk("rst_tready4", 64'(bus4.s_axis_tready), 64'd0);
    chk("rst_tvalid4", 64'(bus4.m_axis_tvalid), 64'd0);
    chk("rst_tdata4",  64'(bus4.m_axis_tdata[63:0]), 64'd0);
    chk("rst_dcnt3",   64'(dcnt3), 64'd0);
    @(posedge clk);
    #1;
    rst      = 1'b0;
    s_vld[0] = 1'b0;
    @(negedge clk);
    chk("post_rst_tready4", 64'(bus4.s_axis_tready), 64'd0);
    chk("post_rst_tvalid4", 64'(bus4.m_axis_tvalid), 64'd0);
    chk("post_rst_tready3", 64'(bus3.s_axis_tready), 64'd0);
    chk("post_rst_dcnt4",   64'(dcnt4), 64'd0);
    @(posedge clk);
    #1;

    // basic route in0 -> out2
    exp_pkt(2, 3, 32'hA000_0000);
    t0 = cyc;
    send_pkt(0, 2, 1'b0, 3, 32'hA000_0000);
    repeat (3) @(posedge clk);
    #1;
    chk("basic_beats",   64'(stamp_q[2].size()), 64'd3);
    chk("basic_latency", 64'(stamp(2, 0) - t0), 64'd2);
    @(negedge clk);
    chk("idle_tdata_zero", 64'(bus4.m_axis_tdata[63:0]), 64'd0);
    chk("idle_tlast_zero", 64'(bus4.m_axis_tlast), 64'd0);
    @(posedge clk);
    #1;

    // contention on out1 from in0, in1, in3
    exp_pkt(1, 2, 32'hB000_0000);
    exp_pkt(1, 2, 32'hB100_0000);
    exp_pkt(1, 2, 32'hB300_0000);
    t0 = cyc;
    fork
      send_pkt(0, 1, 1'b0, 2, 32'hB000_0000);
      send_pkt(1, 1, 1'b0, 2, 32'hB100_0000);
      send_pkt(3, 1, 1'b0, 2, 32'hB300_0000);
    join
    repeat (3) @(posedge clk);
    #1;
    chk("cont_beats",   64'(stamp_q[1].size()), 64'd6);
    chk("cont_latency", 64'(stamp(1, 0) - t0), 64'd2);
    chk("cont_gap1",    64'(stamp(1, 2) - stamp(1, 1)), 64'd2);
    chk("cont_gap2",    64'(stamp(1, 4) - stamp(1, 3)), 64'd2);

    // load balance: tie between out1/out2 goes to out1, and stays there
    stamp_q[1].delete();
    fifo4 = {32'd40, 32'd12, 32'd12, 32'd90};
    exp_pkt(1, 4, 32'hC200_0000);
    fork
      send_pkt(2, 3, 1'b1, 4, 32'hC200_0000);
      begin
        repeat (3) @(posedge clk);
        #1;
        fifo4 = {32'd40, 32'd0, 32'd100, 32'd90};
      end
    join
    repeat (3) @(posedge clk);
    #1;
    chk("lb_beats_out1", 64'(stamp_q[1].size()), 64'd4);

    // single-beat load-balanced packet follows the new minimum to out2
    stamp_q[2].delete();
    exp_pkt(2, 1, 32'hC000_0007);
    t0 = cyc;
    send_pkt(0, 0, 1'b1, 1, 32'hC000_0007);
    repeat (3) @(posedge clk);
    #1;
    chk("single_beats",   64'(stamp_q[2].size()), 64'd1);
    chk("single_latency", 64'(stamp(2, 0) - t0), 64'd2);

    // backpressure on out0
    stamp_q[0].delete();
    exp_pkt(0, 4, 32'hE100_0000);
    fork
      send_pkt(1, 0, 1'b0, 4, 32'hE100_0000);
      begin
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 8; k++) begin
          m_rdy[0] = (k % 2 == 0);
          @(negedge clk);
          if (bus4.m_axis_tvalid[0])
            chk("bp_tready_mirror", 64'(bus4.s_axis_tready[1]), 64'(m_rdy[0]));
          @(posedge clk);
          #1;
        end
        m_rdy[0] = 1'b1;
      end
    join
    repeat (2) @(posedge clk);
    #1;
    chk("bp_beats", 64'(stamp_q[0].size()), 64'd4);
    chk("bp_span",  64'(stamp(0, 3) - stamp(0, 0)), 64'd6);

    // drop path on the 3-port switch
    chk("drop_cnt_init", 64'(dcnt3), 64'd0);
    d3_dst = {2'd3, 2'd0, 2'd0};
    d3_vld = 3'b100;
    @(negedge clk);
    chk("drop_idle_tready", 64'(bus3.s_axis_tready[2]), 64'd0);
    @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) begin
      d3_lst[2] = (k == 3);
      @(negedge clk);
      chk("drop_tready", 64'(bus3.s_axis_tready[2]), 64'd1);
      chk("drop_no_tvalid", 64'(bus3.m_axis_tvalid), 64'd0);
      @(posedge clk);
      #1;
    end
    d3_vld = '0;
    d3_lst = '0;
    @(negedge clk);
    chk("drop_cnt_one", 64'(dcnt3), 64'd1);
    @(posedge clk);
    #1;

    d3_dst = '1;
    d3_vld = '1;
    d3_lst = '1;
    repeat (2) @(posedge clk);
    #1;
    chk("drop_cnt_four", 64'(dcnt3), 64'd4);
    repeat (43998) @(posedge clk);
    #1;
    d3_vld = '0;
    d3_lst = '0;
    @(negedge clk);
    chk("drop_cnt_sat", 64'(dcnt3), 64'hFFFF);
    @(posedge clk);
    #1;

    // reset pulsed while beat 2 of 5 is transferred
    stamp_q[0].delete();
    exp_pkt(0, 5, 32'hF000_0000);
    fork
      send_pkt(0, 0, 1'b0, 5, 32'hF000_0000);
      begin
        tries = 0;
        do begin
          @(negedge clk);
          tries++;
        end while (!(s_dat[0] == 32'hF000_0001 && bus4.s_axis_tready[0]) && tries < 50);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_tready4", 64'(bus4.s_axis_tready), 64'd0);
        chk("mid_rst_tvalid4", 64'(bus4.m_axis_tvalid), 64'd0);
        chk("mid_rst_tvalid3", 64'(bus3.m_axis_tvalid), 64'd0);
        chk("mid_rst_dcnt3",   64'(dcnt3), 64'd0);
      end
    join
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pkt_beats", 64'(stamp_q[0].size()), 64'd5);
    chk("rst_pkt_gap",   64'(stamp(0, 2) - stamp(0, 1)), 64'd3);

    stamp_q[3].delete();
    exp_pkt(3, 2, 32'h9200_0000);
    t0 = cyc;
    send_pkt(2, 3, 1'b0, 2, 32'h9200_0000);
    repeat (3) @(posedge clk);
    #1;
    chk("after_rst_beats",   64'(stamp_q[3].size()), 64'd2);
    chk("after_rst_latency", 64'(stamp(3, 0) - t0), 64'd2);

    for (int o = 0; o < N; o++)
      chk($sformatf("scoreboard_empty_out%0d", o), 64'(exp_q[o].size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
